traffic_light_monitor: RTL and testbench

- Observer at the receiving end of the crossroad controller's lamp/display interface: samples led1, led2 and the 7-segment pattern, decodes them back into phase and digit, and checks the phase sequence and phase durations.
- Used on-chip as a safety checker and in benches as a scoreboard.
- Reports decoded phase, digit, full-cycle count, last phase duration and sticky error flags.

---
 rtl/traffic_light_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: observes the crossroad lamp/7-seg interface, decodes phase and digit,
// and checks phase order and phase durations against the expected tick counts.
// Optional: define SEG_CHECK_EN to enable 7-seg plausibility checking on err_seg.
module traffic_light_monitor #(
    parameter int unsigned DIVISOR    = 125000000,
    parameter int unsigned GREEN_SEC  = 7,
    parameter int unsigned YELLOW_SEC = 2,
    parameter int unsigned TOL        = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [2:0] led1,
    input  logic [2:0] led2,
    input  logic [6:0] seg_in,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic [3:0] digit,
    output logic [7:0] cycle_count,
    output logic [7:0] last_dur,
    output logic       err_code,
    output logic       err_seq,
    output logic       err_time,
    output logic       err_seg,
    output logic       fault
);

    localparam int unsigned    PW        = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIVISOR - 1);
    localparam logic [2:0]     LAMP_RED  = 3'b100;
    localparam logic [2:0]     LAMP_GRN  = 3'b010;
    localparam logic [2:0]     LAMP_YEL  = 3'b110;
    localparam logic signed [8:0] GREEN_S  = 9'(GREEN_SEC);
    localparam logic signed [8:0] YELLOW_S = 9'(YELLOW_SEC);
    localparam logic signed [8:0] TOL_S    = 9'(TOL);

    typedef enum logic [0:0] {StSync, StTrack} state_e;

    logic [2:0]       led1_q, led2_q;
    logic [6:0]       seg_q;
    logic [PW-1:0]    presc_q;
    logic             tick;
    state_e           state_q, state_d;
    logic [7:0]       dur_q, dur_d;
    logic             first_q, first_d;
    logic [1:0]       phase_d;
    logic             valid_d;
    logic [7:0]       cycle_count_d, last_dur_d;
    logic             err_code_d, err_seq_d, err_time_d;
    logic             set_code, set_seq, set_time;
    logic             pair_legal;
    logic [1:0]       pair_phase;
    logic [3:0]       dig_dec;
    logic signed [8:0] exp_dur, dur_diff;
    logic             time_bad;

    assign tick = (presc_q == PRESC_MAX);

    // Stage 1 input sampling and the free-running tick prescaler
    always_ff @(posedge clk_in) begin
        if (rst) begin
            led1_q  <= '0;
            led2_q  <= '0;
            seg_q   <= '0;
            presc_q <= '0;
        end else begin
            led1_q  <= led1;
            led2_q  <= led2;
            seg_q   <= seg_in;
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // Decode the sampled lamp pair into a phase; anything outside the four legal pairs is illegal
    always_comb begin
        pair_legal = 1'b1;
        pair_phase = 2'd0;
        case ({led1_q, led2_q})
            {LAMP_GRN, LAMP_RED}: pair_phase = 2'd0;
            {LAMP_YEL, LAMP_RED}: pair_phase = 2'd1;
            {LAMP_RED, LAMP_GRN}: pair_phase = 2'd2;
            {LAMP_RED, LAMP_YEL}: pair_phase = 2'd3;
            default:              pair_legal = 1'b0;
        endcase
    end

    // Active-low 7-seg decode; blank reads as 15, unknown patterns as 14
    always_comb begin
        case (seg_q)
            7'b1000000: dig_dec = 4'd0;
            7'b1111001: dig_dec = 4'd1;
            7'b0100100: dig_dec = 4'd2;
            7'b0110000: dig_dec = 4'd3;
            7'b0011001: dig_dec = 4'd4;
            7'b0010010: dig_dec = 4'd5;
            7'b0000010: dig_dec = 4'd6;
            7'b1111000: dig_dec = 4'd7;
            7'b0000000: dig_dec = 4'd8;
            7'b0010000: dig_dec = 4'd9;
            7'b1111111: dig_dec = 4'd15;
            default:    dig_dec = 4'd14;
        endcase
    end

    // Duration window check for the phase that is ending; 9-bit signed so nothing wraps
    always_comb begin
        exp_dur  = phase[0] ? YELLOW_S : GREEN_S;
        dur_diff = $signed({1'b0, dur_q}) - exp_dur;
        time_bad = (dur_diff > TOL_S) || (dur_diff < -TOL_S);
    end

    // Stage 2 FSM next state, tracking counters and sticky error flags
    always_comb begin
        state_d       = state_q;
        phase_d       = phase;
        valid_d       = phase_valid;
        dur_d         = dur_q;
        first_d       = first_q;
        last_dur_d    = last_dur;
        cycle_count_d = cycle_count;
        set_code      = 1'b0;
        set_seq       = 1'b0;
        set_time      = 1'b0;
        unique case (state_q)
            StSync: begin
                if (pair_legal) begin
                    state_d = StTrack;
                    phase_d = pair_phase;
                    valid_d = 1'b1;
                    dur_d   = '0;
                    first_d = 1'b1;
                end
            end
            StTrack: begin
                if (!pair_legal) begin
                    set_code = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = StSync;
                end else if (pair_phase != phase) begin
                    // Tick in the change cycle is dropped: the new phase starts at 0
                    phase_d    = pair_phase;
                    last_dur_d = dur_q;
                    dur_d      = '0;
                    first_d    = 1'b0;
                    set_seq    = (pair_phase != phase + 2'd1);
                    set_time   = !first_q && time_bad;
                    if (phase == 2'd3 && pair_phase == 2'd0 && cycle_count != 8'hff) begin
                        cycle_count_d = cycle_count + 8'd1;
                    end
                end else if (tick && dur_q != 8'hff) begin
                    dur_d = dur_q + 8'd1;
                end
            end
            default: state_d = StSync;
        endcase
        // clr resyncs, but an error raised in the same cycle still lands
        if (clr) begin
            state_d = StSync;
            valid_d = 1'b0;
        end
        err_code_d = (err_code & ~clr) | set_code;
        err_seq_d  = (err_seq  & ~clr) | set_seq;
        err_time_d = (err_time & ~clr) | set_time;
    end

    // Stage 2 registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= StSync;
            phase       <= '0;
            phase_valid <= 1'b0;
            digit       <= 4'd15;
            dur_q       <= '0;
            first_q     <= 1'b0;
            last_dur    <= '0;
            cycle_count <= '0;
            err_code    <= 1'b0;
            err_seq     <= 1'b0;
            err_time    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase       <= phase_d;
            phase_valid <= valid_d;
            digit       <= dig_dec;
            dur_q       <= dur_d;
            first_q     <= first_d;
            last_dur    <= last_dur_d;
            cycle_count <= cycle_count_d;
            err_code    <= err_code_d;
            err_seq     <= err_seq_d;
            err_time    <= err_time_d;
        end
    end

`ifdef SEG_CHECK_EN
    logic err_seg_q;
    logic set_seg;

    // Blank/invalid digits, or a count-up within one phase, are display faults while tracking
    always_comb begin
        set_seg = 1'b0;
        if (state_q == StTrack) begin
            if (dig_dec >= 4'd14) begin
                set_seg = 1'b1;
            end else if (pair_legal && pair_phase == phase && dig_dec > digit) begin
                set_seg = 1'b1;
            end
        end
    end

    // Sticky display-fault flag
    always_ff @(posedge clk_in) begin
        if (rst) begin
            err_seg_q <= 1'b0;
        end else begin
            err_seg_q <= (err_seg_q & ~clr) | set_seg;
        end
    end

    assign err_seg = err_seg_q;
`else
    assign err_seg = 1'b0;
`endif

    assign fault = err_code | err_seq | err_time | err_seg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with DIVISOR=4 (one tick every 4 clocks).
// All lamp changes are driven right after clock edges that keep the stage-2 change edge
// two cycles off the tick, so a phase held for 4*N clocks measures exactly N ticks.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b110;
    localparam logic [6:0] SEG9 = 7'b0010000;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG6 = 7'b0000010;
    localparam logic [6:0] SEGB = 7'b1111111;
`ifdef SEG_CHECK_EN
    localparam int SegOn = 1;
`else
    localparam int SegOn = 0;
`endif

    logic       clk_in = 1'b0;
    logic       rst;
    logic [2:0] led1, led2;
    logic [6:0] seg_in;
    logic       clr;
    logic [1:0] phase;
    logic       phase_valid;
    logic [3:0] digit;
    logic [7:0] cycle_count, last_dur;
    logic       err_code, err_seq, err_time, err_seg, fault;

    int checks = 0;
    int failures = 0;

    traffic_light_monitor #(
        .DIVISOR   (4),
        .GREEN_SEC (7),
        .YELLOW_SEC(2),
        .TOL       (1)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .led1       (led1),
        .led2       (led2),
        .seg_in     (seg_in),
        .clr        (clr),
        .phase      (phase),
        .phase_valid(phase_valid),
        .digit      (digit),
        .cycle_count(cycle_count),
        .last_dur   (last_dur),
        .err_code   (err_code),
        .err_seq    (err_seq),
        .err_time   (err_time),
        .err_seg    (err_seg),
        .fault      (fault)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0] ph;
        logic       clr;
        int         hold;
        int         e_phase, e_valid, e_cc, e_last, e_code, e_seq, e_time;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic set_phase(input logic [1:0] ph);
        case (ph)
            2'd0: begin led1 = G; led2 = R; end
            2'd1: begin led1 = Y; led2 = R; end
            2'd2: begin led1 = R; led2 = G; end
            default: begin led1 = R; led2 = Y; end
        endcase
    endtask

    initial begin
        //          ph clr hold phase valid cc last code seq time
        vecs[0]  = '{2'd0, 1'b0, 12, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{2'd1, 1'b0,  8, 1, 1, 0, 3, 0, 0, 0}; // partial first phase, exempt
        vecs[2]  = '{2'd2, 1'b0, 28, 2, 1, 0, 2, 0, 0, 0};
        vecs[3]  = '{2'd3, 1'b0,  8, 3, 1, 0, 7, 0, 0, 0};
        vecs[4]  = '{2'd0, 1'b0, 28, 0, 1, 1, 2, 0, 0, 0}; // full cycle completed
        vecs[5]  = '{2'd1, 1'b0,  8, 1, 1, 1, 7, 0, 0, 0};
        vecs[6]  = '{2'd2, 1'b0, 28, 2, 1, 1, 2, 0, 0, 0};
        vecs[7]  = '{2'd3, 1'b0,  8, 3, 1, 1, 7, 0, 0, 0};
        vecs[8]  = '{2'd0, 1'b0, 36, 0, 1, 2, 2, 0, 0, 0}; // green held 9 ticks
        vecs[9]  = '{2'd1, 1'b0,  8, 1, 1, 2, 9, 0, 0, 1};
        vecs[10] = '{2'd1, 1'b1,  4, 1, 1, 2, 9, 0, 0, 0}; // clr alone, resync
        vecs[11] = '{2'd2, 1'b0, 28, 2, 1, 2, 1, 0, 0, 0}; // partial after clr
        vecs[12] = '{2'd3, 1'b0,  8, 3, 1, 2, 7, 0, 0, 0};
        vecs[13] = '{2'd0, 1'b0, 28, 0, 1, 3, 2, 0, 0, 0};
        vecs[14] = '{2'd2, 1'b0, 28, 2, 1, 3, 7, 0, 1, 0}; // 0 -> 2 skips a phase
        vecs[15] = '{2'd3, 1'b0,  8, 3, 1, 3, 7, 0, 1, 0}; // no new error on 2 -> 3
        vecs[16] = '{2'd3, 1'b1,  8, 3, 1, 3, 7, 0, 0, 0};

        // Reset, with clr also high to show rst dominates
        rst = 1'b1; clr = 1'b1; led1 = 3'b000; led2 = 3'b000; seg_in = SEG9;
        hold(3);
        chk("rst_phase", phase, 0);
        chk("rst_valid", phase_valid, 0);
        chk("rst_digit", digit, 15);
        chk("rst_cc", cycle_count, 0);
        chk("rst_last", last_dur, 0);
        chk("rst_fault", {err_code, err_seq, err_time, err_seg, fault}, 0);
        rst = 1'b0; clr = 1'b0;

        for (int i = 0; i < 17; i++) begin
            set_phase(vecs[i].ph);
            clr = vecs[i].clr;
            hold(1);
            clr = 1'b0;
            hold(vecs[i].hold - 1);
            chk($sformatf("v%0d_phase", i), phase, vecs[i].e_phase);
            chk($sformatf("v%0d_valid", i), phase_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_cc", i), cycle_count, vecs[i].e_cc);
            chk($sformatf("v%0d_last", i), last_dur, vecs[i].e_last);
            chk($sformatf("v%0d_code", i), err_code, vecs[i].e_code);
            chk($sformatf("v%0d_seq", i), err_seq, vecs[i].e_seq);
            chk($sformatf("v%0d_time", i), err_time, vecs[i].e_time);
            chk($sformatf("v%0d_seg", i), err_seg, 0);
            chk($sformatf("v%0d_fault", i), fault,
                vecs[i].e_code | vecs[i].e_seq | vecs[i].e_time);
            chk($sformatf("v%0d_digit", i), digit, 9);
        end

        // clr in the very cycle a 3 -> 1 sequence error is detected: the set wins
        set_phase(2'd1);
        hold(1);
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        chk("clrseq_seq", err_seq, 1);
        chk("clrseq_time", err_time, 0);
        chk("clrseq_phase", phase, 1);
        chk("clrseq_fault", fault, 1);
        hold(2);
        // clr alone clears and resyncs; the resynced phase is exempt from the duration check
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        chk("clr_seq", err_seq, 0);
        chk("clr_fault", fault, 0);
        hold(3);
        hold(36);
        set_phase(2'd2);
        hold(28);
        chk("resync_last", last_dur, 10);
        chk("resync_time", err_time, 0);
        chk("resync_fault", fault, 0);

        // One-cycle illegal lamp code while tracking phase 2
        led1 = 3'b111;
        hold(1);
        set_phase(2'd2);
        hold(1);
        chk("code_valid", phase_valid, 0);
        chk("code_err", err_code, 1);
        hold(2);
        chk("code_revalid", phase_valid, 1);
        chk("code_rephase", phase, 2);
        hold(40);
        set_phase(2'd3);
        hold(8);
        chk("code_last", last_dur, 11);
        chk("code_time", err_time, 0);
        chk("code_seq", err_seq, 0);
        chk("code_sticky", err_code, 1);

        // Display checks: count-up within a phase, then a blank digit
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        hold(3);
        chk("segclr_code", err_code, 0);
        set_phase(2'd0);
        seg_in = SEG5;
        hold(8);
        chk("seg5_digit", digit, 5);
        chk("seg5_err", err_seg, 0);
        chk("seg5_cc", cycle_count, 4);
        seg_in = SEG6;
        hold(4);
        chk("seg6_digit", digit, 6);
        chk("seg6_err", err_seg, SegOn);
        chk("seg6_fault", fault, SegOn);
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        hold(3);
        chk("segclr_seg", err_seg, 0);
        seg_in = SEGB;
        hold(4);
        chk("blank_digit", digit, 15);
        chk("blank_err", err_seg, SegOn);
        chk("blank_code", err_code, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
